// File: rtl/bist_counter_unit_pkg.sv
// Shared definitions for the BIST counter stage and the controller FSM that consumes it.
package bist_counter_unit_pkg;

  localparam logic [1:0] START_EDGE = 2'b01;
  localparam logic [3:0] M_TERM     = 4'd12;

  localparam int N_MAX_DEFAULT = 255;
  localparam int M_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COUNTING_N = 2'd1,
    COUNTING_M = 2'd2,
    FINISH     = 2'd3
  } bist_state_e;

endpackage

// File: rtl/bist_mod_counter.sv
// Modulo-(MAX+1) up-counter with synchronous clear and enable; carry flags count == MAX.
module bist_mod_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Clear outranks enable so a fresh start always begins from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == MAX_V) ? '0 : count + WIDTH'(1);
    end
  end

  assign carry = (count == MAX_V);

endmodule

// File: rtl/bist_counter_unit.sv
// Start-history register plus the N (inner) and M (outer) loop counters feeding the BIST FSM.
module bist_counter_unit
  import bist_counter_unit_pkg::*;
#(
  parameter int N_WIDTH = 8,
  parameter int N_MAX   = N_MAX_DEFAULT,
  parameter int M_WIDTH = 4,
  parameter int M_MAX   = M_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               enable_count_N,
  input  logic               enable_count_M,
  output logic [1:0]         start_val,
  output logic [N_WIDTH-1:0] count_N,
  output logic [M_WIDTH-1:0] count_M,
  output logic               carry_out_N,
  output logic               carry_out_M
);

  logic start_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_val <= 2'b00;
    end else begin
      start_val <= {start_val[0], start};
    end
  end

  // A held start level shows as 2'b11 and never re-triggers.
  assign start_edge = (start_val == START_EDGE);

  bist_mod_counter #(
    .WIDTH (N_WIDTH),
    .MAX   (N_MAX)
  ) u_cnt_n (
    .clk   (clk),
    .reset (reset),
    .clr   (start_edge),
    .en    (enable_count_N),
    .count (count_N),
    .carry (carry_out_N)
  );

  bist_mod_counter #(
    .WIDTH (M_WIDTH),
    .MAX   (M_MAX)
  ) u_cnt_m (
    .clk   (clk),
    .reset (reset),
    .clr   (start_edge),
    .en    (enable_count_M),
    .count (count_M),
    .carry (carry_out_M)
  );

endmodule
